// File: rtl/vga_timing_generator.sv
// 640x480@60 raster timing: pixel-enable divider, h/v counters, syncs, bright,
// and a once-per-frame shadow of the game-state inputs taken at the start of vertical blanking.
module vga_timing_generator #(
    parameter int CLK_DIV = 4,
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525,
    parameter int H_SYNC  = 96,
    parameter int V_SYNC  = 2,
    parameter int H_START = 144,
    parameter int H_END   = 783,
    parameter int V_START = 35,
    parameter int V_END   = 514
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] camera_view_in,
    input  logic [2:0] weapon_state_in,
    input  logic [2:0] enemy_state_in,
    input  logic [2:0] enemy_flags_in,
    output logic       pix_en,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       frame_start,
    output logic [2:0] camera_view,
    output logic [2:0] weapon_state,
    output logic [2:0] enemy_state,
    output logic       forward_enemy_flag,
    output logic       right_enemy_flag,
    output logic       left_enemy_flag
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_C  = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_C  = 10'(V_SYNC);
    localparam logic [9:0] H_START_C = 10'(H_START);
    localparam logic [9:0] H_END_C   = 10'(H_END);
    localparam logic [9:0] V_START_C = 10'(V_START);
    localparam logic [9:0] V_END_C   = 10'(V_END);
    localparam logic [2:0] STATE_IDLE = 3'b001;

    logic [DIV_W-1:0] r_div;
    logic             r_pix_en;
    logic [9:0]       r_h;
    logic [9:0]       r_v;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_bright;
    logic             r_frame_start;
    logic [2:0]       r_camera;
    logic [2:0]       r_weapon;
    logic [2:0]       r_enemy;
    logic [2:0]       r_flags;

    logic [DIV_W-1:0] w_div_next;
    logic [9:0]       w_h_next;
    logic [9:0]       w_v_next;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic             w_latch;
    logic             w_frame_wrap;

    always_comb begin
        w_div_next   = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
        w_h_wrap     = (r_h == H_LAST);
        w_v_wrap     = (r_v == V_LAST);
        w_h_next     = r_h;
        w_v_next     = r_v;
        if (r_pix_en) begin
            if (w_h_wrap) begin
                w_h_next = '0;
                w_v_next = w_v_wrap ? '0 : r_v + 10'd1;
            end else begin
                w_h_next = r_h + 10'd1;
            end
        end
        // First blanking line begins: last pixel of the last visible row rolls over.
        w_latch      = r_pix_en && w_h_wrap && (r_v == V_END_C);
        w_frame_wrap = r_pix_en && w_h_wrap && w_v_wrap;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div         <= '0;
            r_pix_en      <= 1'b0;
            r_h           <= '0;
            r_v           <= '0;
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
            r_bright      <= 1'b0;
            r_frame_start <= 1'b0;
            r_camera      <= STATE_IDLE;
            r_weapon      <= STATE_IDLE;
            r_enemy       <= STATE_IDLE;
            r_flags       <= 3'b000;
        end else begin
            r_div         <= w_div_next;
            r_pix_en      <= (w_div_next == DIV_LAST);
            r_h           <= w_h_next;
            r_v           <= w_v_next;
            // Decoded from next-state counters so they line up with hCount/vCount.
            r_hsync       <= (w_h_next >= H_SYNC_C);
            r_vsync       <= (w_v_next >= V_SYNC_C);
            r_bright      <= (w_h_next >= H_START_C) && (w_h_next <= H_END_C) &&
                             (w_v_next >= V_START_C) && (w_v_next <= V_END_C);
            r_frame_start <= w_frame_wrap;
            if (w_latch) begin
                r_camera <= camera_view_in;
                r_weapon <= weapon_state_in;
                r_enemy  <= enemy_state_in;
                r_flags  <= enemy_flags_in;
            end
        end
    end

    assign pix_en             = r_pix_en;
    assign hCount             = r_h;
    assign vCount             = r_v;
    assign hSync              = r_hsync;
    assign vSync              = r_vsync;
    assign bright             = r_bright;
    assign frame_start        = r_frame_start;
    assign camera_view        = r_camera;
    assign weapon_state       = r_weapon;
    assign enemy_state        = r_enemy;
    assign left_enemy_flag    = r_flags[2];
    assign right_enemy_flag   = r_flags[1];
    assign forward_enemy_flag = r_flags[0];

endmodule

// File: doc/vga_timing_generator.md
# vga_timing_generator

Produces the 640x480@60 Hz raster for the Nexys4 display path: divides the 100 MHz system clock to a pixel-enable strobe and runs the horizontal and vertical counters. From those counters it drives hSync, vSync, bright, hCount and vCount, which the rendering controller consumes. It also captures the game-state inputs once per frame, at the start of vertical blanking, and holds them stable for the whole next visible frame. This keeps camera, weapon and enemy changes from tearing mid-frame.

## Interface
- CLK_DIV, 4, clk cycles per pixel (100 MHz -> 25 MHz)
- H_TOTAL, 800, pixels per line (hCount wraps 799->0)
- V_TOTAL, 525, lines per frame (vCount wraps 524->0)
- H_SYNC, 96, hSync low while hCount < H_SYNC
- V_SYNC, 2, vSync low while vCount < V_SYNC
- H_START / H_END, 144 / 783, visible columns (inclusive)
- V_START / V_END, 35 / 514, visible rows (inclusive)
- clk  in  1  system clock, 100 MHz, rising edge
- rst_n  in  1  synchronous, active-low reset
- camera_view_in  in  3  camera state from camera SM (001 Forward, 011 Left, 110 Right, others transitional)
- weapon_state_in  in  3  gun SM state (001 idle)
- enemy_state_in  in  3  enemy SM state (001 title/idle)
- enemy_flags_in  in  3  {left, right, forward} enemy-present flags
- pix_en  out  1  one-clk strobe; counters advance on this cycle's edge
- hCount  out  10  horizontal position 0..H_TOTAL-1
- vCount  out  10  vertical position 0..V_TOTAL-1
- hSync  out  1  active-low horizontal sync
- vSync  out  1  active-low vertical sync
- bright  out  1  1 iff H_START<=hCount<=H_END and V_START<=vCount<=V_END
- frame_start  out  1  one-clk pulse when (hCount,vCount) becomes (0,0)
- camera_view, weapon_state, enemy_state  out  3 each  frame-latched copies
- forward_enemy_flag, right_enemy_flag, left_enemy_flag  out  1 each  frame-latched flags

## Operation
- Divider: div counts 0..CLK_DIV-1 and wraps. pix_en is registered and is 1 for exactly one clk when div==CLK_DIV-1.
- Counters advance on the clk edge where pix_en==1:
  - hCount increments.
  - At H_TOTAL-1, hCount goes to 0 and vCount increments.
  - At V_TOTAL-1 with hCount at H_TOTAL-1, vCount goes to 0.
- hSync, vSync and bright are registered. They are computed from the next counter values, so they always match the hCount/vCount presented in the same cycle. There is no pipeline skew.
- frame_start is registered. It goes high on the edge where the counters load (0,0) and is cleared on the next clk.
- State latch: the shadow registers load all game-state inputs on the pix_en edge where hCount goes 799->0 and vCount goes V_END->V_END+1 (514->515). That is the first blanking line. The shadows hold until the next such edge.
- Input changes at any other time have no effect on the outputs until the next latch point.
- Reset (rst_n==0 at a clk edge):
  - div=0, pix_en=0, hCount=0, vCount=0, hSync=0, vSync=0, bright=0, frame_start=0.
  - camera_view=3'b001, weapon_state=3'b001, enemy_state=3'b001, all enemy flags=0.
- Reset mid-line or mid-frame aborts the current frame immediately. No frame_start is emitted for the (0,0) state forced by reset.
- The first pix_en after reset release occurs CLK_DIV clks later.

## Timing
- Latency: after the rst_n rising edge, the first pix_en is asserted at clk CLK_DIV (counting the first clk with rst_n=1 as 1), and hCount becomes 1 on that edge.
- Line: 800 x 4 = 3200 clks. Frame: 525 lines = 1,680,000 clks.
- hSync low for hCount 0..95 (384 clks). vSync low for vCount 0..1 (6400 clks).
- bright is high for 640 pixels on each of rows 35..514. It is low everywhere else, including all of row 515.
- Latch edge and the corresponding frame_start are 10 lines (32,000 clks) apart. The latched values are stable for the entire visible region of the following frame.
- Boundary: the simultaneous hCount and vCount wrap at (799,524) produces (0,0) in a single edge, with vSync falling and frame_start rising on that same edge.

## Test plan
- Reset release, CLK_DIV=4 -> pix_en pulses at clks 4, 8, 12, and so on. hCount=0, vCount=0 and all syncs 0 until the first pulse.
- Run 1 line -> exactly 800 pix_en strobes. hSync low for hCount 0..95. hCount wraps 799->0 and vCount increments 0->1 on the same edge.
- Run 2 frames -> frame_start pulses exactly 1,680,000 clks apart. vSync low for 6400 clks per frame. bright high for 640x480 = 307,200 pixels per frame.
- Corner check -> bright=0 at (143,35), 1 at (144,35), 1 at (783,514), 0 at (784,514) and 0 at (144,515).
- Change camera_view_in 001->110 at row 200 -> camera_view stays 001 through row 514. It becomes 110 on the 514->515 edge and holds through the next frame's rows 35..514.
- Assert rst_n=0 at (400,300) for one clk -> all outputs return to reset values on that edge. No frame_start pulse. Counting restarts exactly as in the first scenario.
